// File: rtl/posit_add_result_checker_pkg.sv
// Shared constants and helpers for the posit adder result checker.
package posit_add_result_checker_pkg;

    localparam int unsigned POSIT_N  = 32;
    localparam int unsigned POSIT_ES = 3;
    localparam logic [POSIT_N-1:0] POSIT_NAR = {1'b1, {(POSIT_N-1){1'b0}}};

    // Wide enough for any posit width this checker is built for (N <= 64).
    localparam int unsigned DIFF_W = 64;

    function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                   input logic [DIFF_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/posit_delay_line.sv
// Fixed-depth shift register carrying a valid bit plus payload; only the valid bits are reset.
module posit_delay_line #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [DEPTH-1:0] valid_q;
    logic [W-1:0]     data_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        data_q[0] <= in_data;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/posit_add_result_checker.sv
// Compares delayed expected posit sums against the adder output and keeps
// saturating pass/fail statistics for on-board regression.
module posit_add_result_checker
    import posit_add_result_checker_pkg::*;
#(
    parameter int unsigned N       = POSIT_N,
    parameter int unsigned ES      = POSIT_ES,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned TOL     = 0,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     exp_in,
    input  logic             done,
    input  logic [N-1:0]     result,
    input  logic             inf,
    input  logic             zero,
    output logic             chk_valid,
    output logic             mismatch,
    output logic [N-1:0]     diff,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [N-1:0]     max_diff,
    output logic             align_err,
    output logic             sat
);

    localparam logic [N-1:0]     NAR_W   = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]     TOL_W   = N'(TOL);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
        $error("posit_add_result_checker: LATENCY must be 1..16");
    end
    if (ES >= N || N > DIFF_W) begin : g_bad_width
        $error("posit_add_result_checker: unsupported N/ES combination");
    end

    logic         tail_valid;
    logic [N-1:0] tail_exp;

    posit_delay_line #(
        .DEPTH (LATENCY),
        .W     (N)
    ) u_dly (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (start),
        .in_data   (exp_in),
        .out_valid (tail_valid),
        .out_data  (tail_exp)
    );

    logic         cmp_c;
    logic         misalign_c;
    logic         mis_c;
    logic [N-1:0] diff_c;

    // Raw unsigned word distance plus flag consistency; no posit decoding.
    always_comb begin
        cmp_c      = done & tail_valid;
        misalign_c = done ^ tail_valid;
        diff_c     = N'(abs_diff(DIFF_W'(tail_exp), DIFF_W'(result)));
        mis_c      = (diff_c > TOL_W)
                   | (inf  != (tail_exp == NAR_W))
                   | (zero != (tail_exp == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_valid    <= 1'b0;
            mismatch     <= 1'b0;
            diff         <= '0;
            sample_count <= '0;
            err_count    <= '0;
            max_diff     <= '0;
            align_err    <= 1'b0;
            sat          <= 1'b0;
        end else begin
            chk_valid <= cmp_c;
            if (misalign_c) begin
                align_err <= 1'b1;
            end
            if (cmp_c) begin
                mismatch <= mis_c;
                diff     <= diff_c;
                if (diff_c > max_diff) begin
                    max_diff <= diff_c;
                end
                // Counters stick at all-ones; sat marks the moment either one gets there.
                if (sample_count != CNT_MAX) begin
                    sample_count <= sample_count + CNT_ONE;
                    if (sample_count == CNT_MAX - CNT_ONE) begin
                        sat <= 1'b1;
                    end
                end
                if (mis_c && err_count != CNT_MAX) begin
                    err_count <= err_count + CNT_ONE;
                    if (err_count == CNT_MAX - CNT_ONE) begin
                        sat <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_posit_add_result_checker.sv
// Directed bench: three checker instances (default, TOL=2, CNT_W=4) share one stimulus.
module tb_posit_add_result_checker;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] exp_in;
    logic        done;
    logic [31:0] result;
    logic        inf;
    logic        zero;

    logic        chk_valid0, mismatch0, align_err0, sat0;
    logic [31:0] diff0, sample_count0, err_count0, max_diff0;
    logic        chk_valid1, mismatch1, align_err1, sat1;
    logic [31:0] diff1, sample_count1, err_count1, max_diff1;
    logic        chk_valid2, mismatch2, align_err2, sat2;
    logic [31:0] diff2, max_diff2;
    logic [3:0]  sample_count2, err_count2;

    int errors = 0;
    int checks = 0;
    int pulses;

    always #5 clk = ~clk;

    posit_add_result_checker #(.N(32), .ES(3), .LATENCY(LAT), .TOL(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .start(start), .exp_in(exp_in), .done(done), .result(result),
        .inf(inf), .zero(zero), .chk_valid(chk_valid0), .mismatch(mismatch0), .diff(diff0),
        .sample_count(sample_count0), .err_count(err_count0), .max_diff(max_diff0),
        .align_err(align_err0), .sat(sat0));

    posit_add_result_checker #(.N(32), .ES(3), .LATENCY(LAT), .TOL(2), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst), .start(start), .exp_in(exp_in), .done(done), .result(result),
        .inf(inf), .zero(zero), .chk_valid(chk_valid1), .mismatch(mismatch1), .diff(diff1),
        .sample_count(sample_count1), .err_count(err_count1), .max_diff(max_diff1),
        .align_err(align_err1), .sat(sat1));

    posit_add_result_checker #(.N(32), .ES(3), .LATENCY(LAT), .TOL(0), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start), .exp_in(exp_in), .done(done), .result(result),
        .inf(inf), .zero(zero), .chk_valid(chk_valid2), .mismatch(mismatch2), .diff(diff2),
        .sample_count(sample_count2), .err_count(err_count2), .max_diff(max_diff2),
        .align_err(align_err2), .sat(sat2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start  = 1'b0;
        exp_in = '0;
        done   = 1'b0;
        result = '0;
        inf    = 1'b0;
        zero   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // One operand pair with done exactly LAT cycles after start; returns one cycle after done.
    task automatic sample(input logic [31:0] e, input logic [31:0] r,
                          input logic f_inf, input logic f_zero);
        start  = 1'b1;
        exp_in = e;
        step();
        start  = 1'b0;
        exp_in = '0;
        repeat (LAT - 1) step();
        done   = 1'b1;
        result = r;
        inf    = f_inf;
        zero   = f_zero;
        step();
        idle_inputs();
    endtask

    // Back-to-back stream; result = expected + off. Optional one-cycle rst at step rst_at.
    task automatic run_stream(input int n, input int rst_at, input logic [31:0] off,
                              output int npulses);
        npulses = 0;
        for (int k = 0; k < n + LAT + 2; k++) begin
            start  = (k < n);
            exp_in = 32'h4000_0000 + 32'(k);
            done   = (k >= LAT) && (k - LAT < n);
            result = 32'h4000_0000 + 32'(k - LAT) + off;
            rst    = (k == rst_at);
            step();
            if (chk_valid0) npulses++;
            if (k == rst_at) begin
                check("rst_mid.chk_valid", 32'(chk_valid0), 32'd0);
                check("rst_mid.mismatch", 32'(mismatch0), 32'd0);
                check("rst_mid.diff", diff0, 32'd0);
                check("rst_mid.sample_count", sample_count0, 32'd0);
                check("rst_mid.err_count", err_count0, 32'd0);
                check("rst_mid.max_diff", max_diff0, 32'd0);
                check("rst_mid.align_err", 32'(align_err0), 32'd0);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        do_reset();

        check("reset.chk_valid", 32'(chk_valid0), 32'd0);
        check("reset.mismatch", 32'(mismatch0), 32'd0);
        check("reset.diff", diff0, 32'd0);
        check("reset.sample_count", sample_count0, 32'd0);
        check("reset.err_count", err_count0, 32'd0);
        check("reset.max_diff", max_diff0, 32'd0);
        check("reset.align_err", 32'(align_err0), 32'd0);
        check("reset.sat", 32'(sat0), 32'd0);
        step();

        sample(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
        check("single.chk_valid", 32'(chk_valid0), 32'd1);
        check("single.mismatch", 32'(mismatch0), 32'd0);
        check("single.diff", diff0, 32'd0);
        check("single.sample_count", sample_count0, 32'd1);
        check("single.err_count", err_count0, 32'd0);
        step();
        check("single.pulse_end", 32'(chk_valid0), 32'd0);

        sample(32'h4000_0000, 32'h4000_0002, 1'b0, 1'b0);
        check("off2.mismatch", 32'(mismatch0), 32'd1);
        check("off2.diff", diff0, 32'd2);
        check("off2.err_count", err_count0, 32'd1);
        check("off2.max_diff", max_diff0, 32'd2);
        check("off2.sample_count", sample_count0, 32'd2);
        check("off2_tol2.mismatch", 32'(mismatch1), 32'd0);
        check("off2_tol2.err_count", err_count1, 32'd0);
        step();
        check("off2.hold_mismatch", 32'(mismatch0), 32'd1);
        check("off2.hold_diff", diff0, 32'd2);
        check("off2.no_pulse", 32'(chk_valid0), 32'd0);

        sample(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        check("nar_noinf.mismatch", 32'(mismatch0), 32'd1);
        check("nar_noinf.err_count", err_count0, 32'd2);
        check("nar_noinf_tol2.mismatch", 32'(mismatch1), 32'd1);

        sample(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        check("nar_inf.mismatch", 32'(mismatch0), 32'd0);

        sample(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
        check("zero_ok.mismatch", 32'(mismatch0), 32'd0);
        check("zero_ok.sample_count", sample_count0, 32'd5);
        check("zero_ok.err_count", err_count0, 32'd2);

        sample(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        check("zero_noflag.mismatch", 32'(mismatch0), 32'd1);
        check("zero_noflag.err_count", err_count0, 32'd3);

        sample(32'h4000_0010, 32'h4000_0000, 1'b0, 1'b0);
        check("exp_gt.diff", diff0, 32'h10);
        check("exp_gt.max_diff", max_diff0, 32'h10);
        check("exp_gt.err_count", err_count0, 32'd4);
        check("exp_gt_tol2.mismatch", 32'(mismatch1), 32'd1);

        // done one cycle early
        start  = 1'b1;
        exp_in = 32'h4000_0000;
        step();
        start  = 1'b0;
        repeat (LAT - 2) step();
        done   = 1'b1;
        result = 32'h4000_0000;
        step();
        idle_inputs();
        check("misalign.align_err", 32'(align_err0), 32'd1);
        check("misalign.chk_valid", 32'(chk_valid0), 32'd0);
        check("misalign.sample_count", sample_count0, 32'd7);
        repeat (3) step();
        check("misalign.sticky", 32'(align_err0), 32'd1);
        check("misalign.sample_hold", sample_count0, 32'd7);
        check("misalign.err_hold", err_count0, 32'd4);

        do_reset();
        check("rst2.align_err", 32'(align_err0), 32'd0);
        check("rst2.max_diff", max_diff0, 32'd0);

        run_stream(1000, -1, 32'd0, pulses);
        check("stream.pulses", 32'(pulses), 32'd1000);
        check("stream.sample_count", sample_count0, 32'd1000);
        check("stream.err_count", err_count0, 32'd0);
        check("stream.align_err", 32'(align_err0), 32'd0);
        check("stream.sat", 32'(sat0), 32'd0);
        check("stream_cnt4.sample_count", 32'(sample_count2), 32'd15);
        check("stream_cnt4.sat", 32'(sat2), 32'd1);

        do_reset();
        run_stream(20, 10, 32'd0, pulses);
        check("rst_mid.stale_align", 32'(align_err0), 32'd1);
        check("rst_mid.post_samples", sample_count0, 32'd9);
        check("rst_mid.post_errors", err_count0, 32'd0);

        do_reset();
        run_stream(20, -1, 32'd2, pulses);
        check("sat.err_count", err_count0, 32'd20);
        check("sat.max_diff", max_diff0, 32'd2);
        check("sat.sat_wide", 32'(sat0), 32'd0);
        check("sat_cnt4.err_count", 32'(err_count2), 32'd15);
        check("sat_cnt4.sample_count", 32'(sample_count2), 32'd15);
        check("sat_cnt4.sat", 32'(sat2), 32'd1);
        check("sat_tol2.err_count", err_count1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/posit_add_result_checker.md
Name: posit_add_result_checker

Overview:
- In-fabric result checker on the output side of the 32-bit es=3 posit adder pipeline.
- Takes the expected sum for every operand pair issued to the adder and delays it by the adder latency.
- Compares that expected sum against the adder's result, inf and zero outputs when done asserts.
- Accumulates sample, error and max-difference statistics for on-board regression without a simulator.

Parameters:
- N, 32, posit word width.
- ES, 3, exponent size. Used only for documentation and NaR constant selection.
- LATENCY, 4, adder cycles from start/operands to done/result. Legal range 1..16.
- TOL, 0, largest |expected - result| still counted as a pass.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, operand pair issued to the adder this cycle.
- exp_in, input, N, expected posit sum for the pair issued this cycle.
- done, input, 1, adder result valid.
- result, input, N, adder result.
- inf, input, 1, adder NaR flag.
- zero, input, 1, adder zero flag.
- chk_valid, output, 1, one-cycle pulse: a comparison completed.
- mismatch, output, 1, qualifies chk_valid: the comparison failed.
- diff, output, N, |expected - result| of the last comparison.
- sample_count, output, CNT_W, number of comparisons.
- err_count, output, CNT_W, number of failed comparisons.
- max_diff, output, N, largest diff seen.
- align_err, output, 1, sticky: done and the delayed expected-valid disagreed.
- sat, output, 1, sticky: a counter saturated.

Behaviour:
- Reset:
  - All outputs go to 0 and the delay line is invalidated.
  - rst mid-stream discards in-flight expectations; the first comparison after reset needs start at or after the reset-release cycle.
- Delay line:
  - LATENCY-stage shift register of {valid, exp}, advancing every cycle.
  - Stage 0 loads {start, exp_in}.
  - Tail entry at cycle t+LATENCY corresponds to start at cycle t.
- Compare condition: at cycle c, compare when done==1 and tail.valid==1. Results register at c+1.
  - chk_valid=1 for exactly one cycle.
  - diff = exp > result ? exp-result : result-exp, as an unsigned N-bit compare (no posit decoding).
  - mismatch=1 if diff > TOL, or inf != (exp == 1<<(N-1)), or zero != (exp == 0).
  - sample_count increments; err_count increments if mismatch.
  - max_diff updates if diff > max_diff.
- Alignment:
  - done XOR tail.valid sets align_err, which holds until rst.
  - No comparison is made that cycle and counters do not change.
- Back-to-back operation: start every cycle gives one comparison per cycle. No throughput gaps.
- Counters saturate at all-ones, do not wrap, and set sat. sat and align_err are sticky.
- diff and mismatch hold their last values between chk_valid pulses.
- No handshake back to the producer: the checker never stalls.

Decomposition:
- Shared package holds:
  - N, ES;
  - NAR = 1<<(N-1);
  - the absolute-difference function, also reused by the error-statistics logic.
- One natural sub-module: posit_delay_line (parameterised depth and width, valid bit plus payload), reused for future pipelined posit units.

Test Plan:
- Single sample:
  - start at cycle 10 with exp_in=0x40000000; done at cycle 14 with result=0x40000000.
  - Expect chk_valid at cycle 15, mismatch=0, diff=0, sample_count=1, err_count=0.
- Off-by-two: result=0x40000002 with exp=0x40000000, TOL=0.
  - Expect mismatch=1, diff=2, err_count=1, max_diff=2.
  - Repeat with TOL=2 -> mismatch=0.
- Flags:
  - exp=0x80000000 with inf=0 -> mismatch=1.
  - exp=0 with zero=1 and result=0 -> mismatch=0.
- Misalignment:
  - done asserted at cycle 13 for a start at cycle 10 -> align_err=1 (sticky), no chk_valid, counters unchanged.
- Stream and reset:
  - 1000 back-to-back samples -> 1000 chk_valid pulses, sample_count=1000.
  - rst asserted mid-stream -> all outputs 0 next cycle; the stale done after reset sets align_err.
- Saturation: with CNT_W=4, 20 failing samples -> err_count=15, sat=1.
